// File: rtl/int_sched_pkg.sv
// Shared constants and types for the int_sched interrupt scheduler.
package int_sched_pkg;

    localparam int NSRC_MAX = 8;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_ENABLE   = 8'h02;
    localparam logic [7:0] REG_PENDING  = 8'h04;
    localparam logic [7:0] REG_VBASE    = 8'h06;
    localparam logic [7:0] REG_LEVEL_LO = 8'h08;
    localparam logic [7:0] REG_LEVEL_HI = 8'h0A;

    localparam logic [7:0] SPURIOUS_VEC = 8'h18;
    localparam logic [7:0] VBASE_RST    = 8'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        IACK = 2'd2,
        HOLD = 2'd3
    } bus_state_t;

    // Word-address match; the byte bit of the address is ignored.
    function automatic logic reg_hit(input logic [7:0] a, input logic [7:0] offset);
        return a[7:1] == offset[7:1];
    endfunction

endpackage

// File: rtl/int_prio_sel.sv
// Combinational priority resolver: highest active level for ipl_n, and the
// lowest-index active source whose level matches the acknowledged level.
module int_prio_sel
    import int_sched_pkg::*;
(
    input  logic [NSRC_MAX-1:0]      active,
    input  logic [NSRC_MAX-1:0][2:0] level,
    input  logic [2:0]               iack_level,
    output logic [2:0]               max_level,
    output logic [2:0]               win_idx,
    output logic                     win_valid
);

    // Scan for the maximum level, then scan downward so the lowest index wins.
    always_comb begin
        max_level = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        for (int i = 0; i < NSRC_MAX; i++) begin
            if (active[i] && (level[i] > max_level)) begin
                max_level = level[i];
            end
        end
        for (int i = NSRC_MAX - 1; i >= 0; i--) begin
            if (active[i] && (level[i] == iack_level)) begin
                win_idx   = 3'(i);
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_sched.sv
// Programmable-priority vectored interrupt scheduler for the 68000 bus.
//
// state | meaning
// IDLE  | waiting for an address strobe
// ACC   | register read/write cycle, ack and read data registered on exit
// IACK  | interrupt-acknowledge cycle, vector driven and winner cleared
// HOLD  | transfer done, waiting for the strobe to drop
module int_sched
    import int_sched_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     data_write,
    output logic [15:0]     data_read,
    input  logic [7:0]      addr,
    input  logic            uds,
    input  logic            lds,
    input  logic            rw,
    input  logic            as,
    input  logic            iack,
    input  logic [2:0]      iack_level,
    output logic            ack,
    input  logic [NSRC-1:0] irq,
    output logic [2:0]      ipl_n
);

    bus_state_t                state_q, state_d;
    logic                      ctrl_en;
    logic [7:0]                enable_q;
    logic [7:0]                pending_q;
    logic [7:3]                vbase_q;
    logic [7:0][2:0]           level_q;
    logic [7:0]                irq_ext;
    logic [7:0]                sync1_q, sync2_q, sync3_q;
    logic [7:0]                irq_edge;
    logic [7:0]                level_nz;
    logic [7:0]                active;
    logic [7:0]                pend_clr;
    logic [15:0]               rd_val;
    logic [15:0]               lane_mask;
    logic [2:0]                max_level;
    logic [2:0]                win_idx;
    logic                      win_valid;
    logic                      wr_cycle;
    logic                      unused_bits;

    assign unused_bits = ^{data_write[15], data_write[11], addr[0]};

    // Zero-extend the request vector to the fixed 8-source register layout.
    always_comb begin
        irq_ext = '0;
        irq_ext[NSRC-1:0] = irq;
    end

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= irq_ext;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign irq_edge = sync2_q & ~sync3_q;

    // A source takes part in arbitration only with a non-zero level.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            level_nz[i] = level_q[i] != 3'd0;
        end
        active = pending_q & enable_q & {8{ctrl_en}} & level_nz;
    end

    int_prio_sel u_prio_sel (
        .active     (active),
        .level      (level_q),
        .iack_level (iack_level),
        .max_level  (max_level),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    // Bus FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (as) state_d = iack ? IACK : ACC;
            ACC:  state_d = HOLD;
            IACK: state_d = HOLD;
            HOLD: if (!as) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wr_cycle = (state_q == ACC) && !rw;

    // Pending bits to clear this cycle: W1C writes and the IACK winner.
    always_comb begin
        pend_clr = '0;
        if (wr_cycle && lds && reg_hit(addr, REG_PENDING)) begin
            pend_clr = data_write[7:0];
        end
        if ((state_q == IACK) && win_valid) begin
            pend_clr = pend_clr | (8'b1 << win_idx);
        end
    end

    // Register file; a new edge overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_en   <= 1'b0;
            enable_q  <= '0;
            pending_q <= '0;
            vbase_q   <= VBASE_RST[7:3];
            level_q   <= '0;
        end else begin
            pending_q <= (pending_q & ~pend_clr) | (irq_edge & enable_q);
            if (wr_cycle) begin
                if (lds && reg_hit(addr, REG_CTRL))   ctrl_en  <= data_write[0];
                if (lds && reg_hit(addr, REG_ENABLE)) enable_q <= data_write[7:0];
                if (lds && reg_hit(addr, REG_VBASE))  vbase_q  <= data_write[7:3];
                if (reg_hit(addr, REG_LEVEL_LO)) begin
                    if (lds) begin
                        level_q[0] <= data_write[2:0];
                        level_q[1] <= data_write[6:4];
                    end
                    if (uds) begin
                        level_q[2] <= data_write[10:8];
                        level_q[3] <= data_write[14:12];
                    end
                end
                if (reg_hit(addr, REG_LEVEL_HI)) begin
                    if (lds) begin
                        level_q[4] <= data_write[2:0];
                        level_q[5] <= data_write[6:4];
                    end
                    if (uds) begin
                        level_q[6] <= data_write[10:8];
                        level_q[7] <= data_write[14:12];
                    end
                end
            end
        end
    end

    // Read mux for the register map; unmapped offsets read as zero.
    always_comb begin
        rd_val = '0;
        if (reg_hit(addr, REG_CTRL)) begin
            rd_val = {15'd0, ctrl_en};
        end else if (reg_hit(addr, REG_ENABLE)) begin
            rd_val = {8'd0, enable_q};
        end else if (reg_hit(addr, REG_PENDING)) begin
            rd_val = {8'd0, pending_q};
        end else if (reg_hit(addr, REG_VBASE)) begin
            rd_val = {8'd0, vbase_q, 3'b000};
        end else if (reg_hit(addr, REG_LEVEL_LO)) begin
            rd_val = {1'b0, level_q[3], 1'b0, level_q[2], 1'b0, level_q[1], 1'b0, level_q[0]};
        end else if (reg_hit(addr, REG_LEVEL_HI)) begin
            rd_val = {1'b0, level_q[7], 1'b0, level_q[6], 1'b0, level_q[5], 1'b0, level_q[4]};
        end
        lane_mask = {{8{uds}}, {8{lds}}};
    end

    // Registered bus outputs and priority level to the CPU.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack       <= 1'b0;
            data_read <= '0;
            ipl_n     <= 3'b111;
        end else begin
            ack       <= (state_q == ACC) || (state_q == IACK);
            data_read <= '0;
            if ((state_q == ACC) && rw) begin
                data_read <= rd_val & lane_mask;
            end else if (state_q == IACK) begin
                data_read <= {8'd0, (win_valid ? {vbase_q, win_idx} : SPURIOUS_VEC)};
            end
            ipl_n <= ~max_level;
        end
    end

endmodule

// File: tb/tb_int_sched.sv
// Self-checking bench for int_sched: register table, directed corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_int_sched;

    logic        clk;
    logic        reset_n;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic [7:0]  addr;
    logic        uds, lds, rw, as, iack;
    logic [2:0]  iack_level;
    logic        ack;
    logic [7:0]  irq;
    logic [2:0]  ipl_n;

    int checks   = 0;
    int failures = 0;

    int m_ctrl, m_en, m_pend, m_vbase;
    int m_lvl[8];

    int_sched #(.NSRC(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_write (data_write),
        .data_read  (data_read),
        .addr       (addr),
        .uds        (uds),
        .lds        (lds),
        .rw         (rw),
        .as         (as),
        .iack       (iack),
        .iack_level (iack_level),
        .ack        (ack),
        .irq        (irq),
        .ipl_n      (ipl_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [15:0] d;
        bit          u;
        bit          l;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[24];

    function automatic void m_reset();
        m_ctrl = 0; m_en = 0; m_pend = 0; m_vbase = 'h40;
        for (int i = 0; i < 8; i++) m_lvl[i] = 0;
    endfunction

    function automatic int m_read(input int a, input bit u, input bit l);
        int v;
        int msk;
        v = 0;
        case (a & 'hFE)
            'h00: v = m_ctrl;
            'h02: v = m_en;
            'h04: v = m_pend;
            'h06: v = m_vbase;
            'h08: for (int j = 0; j < 4; j++) v = v + (m_lvl[j] << (4 * j));
            'h0A: for (int j = 0; j < 4; j++) v = v + (m_lvl[4 + j] << (4 * j));
            default: v = 0;
        endcase
        msk = (u ? 'hFF00 : 0) + (l ? 'h00FF : 0);
        return v & msk;
    endfunction

    function automatic void m_write(input int a, input int d, input bit u, input bit l);
        case (a & 'hFE)
            'h00: if (l) m_ctrl = d & 1;
            'h02: if (l) m_en = d & 'hFF;
            'h04: if (l) m_pend = m_pend & ~(d & 'hFF);
            'h06: if (l) m_vbase = d & 'hF8;
            'h08, 'h0A: begin
                for (int j = 0; j < 4; j++) begin
                    if ((j < 2) ? l : u) m_lvl[((a & 'hFE) == 'h0A ? 4 : 0) + j] = (d >> (4 * j)) & 7;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic bit m_active(input int i);
        return ((m_pend >> i) & 1) == 1 && ((m_en >> i) & 1) == 1 && m_ctrl == 1 && m_lvl[i] != 0;
    endfunction

    function automatic int m_ipl();
        int mx;
        mx = 0;
        for (int i = 0; i < 8; i++) if (m_active(i) && m_lvl[i] > mx) mx = m_lvl[i];
        return 7 - mx;
    endfunction

    function automatic int m_iack(input int lv);
        for (int i = 0; i < 8; i++) begin
            if (m_active(i) && m_lvl[i] == lv) begin
                m_pend = m_pend & ~(1 << i);
                return m_vbase + i;
            end
        end
        return 'h18;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_cycle(input bit is_iack, input logic [2:0] lv, input bit rd,
                             input logic [7:0] a, input logic [15:0] wd, input bit u, input bit l,
                             input int hold, output logic [15:0] rdata, output int nack,
                             output int ack_at, output logic [2:0] ipl_ack, output logic [2:0] ipl_after);
        rdata = '0; nack = 0; ack_at = -1; ipl_ack = '0; ipl_after = '0;
        @(posedge clk); #1;
        addr = a; data_write = wd; uds = u; lds = l; rw = rd;
        iack = is_iack; iack_level = lv; as = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (ack_at >= 0 && c == ack_at + 1) ipl_after = ipl_n;
            if (ack === 1'b1) begin
                nack++;
                if (ack_at < 0) begin
                    ack_at = c; rdata = data_read; ipl_ack = ipl_n;
                end
            end
        end
        @(posedge clk); #1;
        as = 1'b0; iack = 1'b0; rw = 1'b1; uds = 1'b0; lds = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit u, input bit l);
        logic [15:0] rd; int n, at; logic [2:0] p0, p1;
        bus_cycle(1'b0, 3'd0, 1'b0, a, d, u, l, 4, rd, n, at, p0, p1);
        check("write_ack_count", n, 1);
        check("write_ack_latency", at, 2);
        m_write(int'(a), int'(d), u, l);
    endtask

    task automatic do_read(input logic [7:0] a, input bit u, input bit l, output logic [15:0] rd);
        int n, at; logic [2:0] p0, p1;
        bus_cycle(1'b0, 3'd0, 1'b1, a, 16'h0, u, l, 4, rd, n, at, p0, p1);
        check("read_ack_count", n, 1);
        check("read_data", int'(rd), m_read(int'(a), u, l));
    endtask

    task automatic do_iack(input logic [2:0] lv, output logic [15:0] rd,
                           output logic [2:0] p_ack, output logic [2:0] p_after);
        int n, at;
        bus_cycle(1'b1, lv, 1'b1, 8'h00, 16'h0, 1'b1, 1'b1, 4, rd, n, at, p_ack, p_after);
        check("iack_ack_count", n, 1);
        check("iack_vector", int'(rd), m_iack(int'(lv)));
    endtask

    task automatic pulse_irq(input logic [7:0] mask);
        @(posedge clk); #1 irq = mask;
        repeat (4) @(posedge clk);
        #1 irq = 8'h00;
        repeat (4) @(posedge clk);
        m_pend = m_pend | (int'(mask) & m_en);
    endtask

    initial begin
        logic [15:0] rd;
        logic [2:0]  pa, pf;
        int          n, at;
        logic [7:0]  ra;

        reset_n = 1'b0; data_write = '0; addr = '0; uds = 0; lds = 0; rw = 1;
        as = 0; iack = 0; iack_level = '0; irq = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_ipl_n", int'(ipl_n), 7);
        check("reset_ack", int'(ack), 0);
        check("reset_data_read", int'(data_read), 0);

        tbl[0]  = '{0, 8'h00, 16'h0000, 1, 1, 16'h0000};
        tbl[1]  = '{0, 8'h02, 16'h0000, 1, 1, 16'h0000};
        tbl[2]  = '{0, 8'h04, 16'h0000, 1, 1, 16'h0000};
        tbl[3]  = '{0, 8'h06, 16'h0000, 1, 1, 16'h0040};
        tbl[4]  = '{0, 8'h08, 16'h0000, 1, 1, 16'h0000};
        tbl[5]  = '{0, 8'h0A, 16'h0000, 1, 1, 16'h0000};
        tbl[6]  = '{0, 8'h0C, 16'h0000, 1, 1, 16'h0000};
        tbl[7]  = '{1, 8'h07, 16'hFFFF, 0, 1, 16'h0000};
        tbl[8]  = '{0, 8'h06, 16'h0000, 1, 1, 16'h00F8};
        tbl[9]  = '{1, 8'h0A, 16'h7777, 1, 0, 16'h0000};
        tbl[10] = '{0, 8'h0A, 16'h0000, 1, 1, 16'h7700};
        tbl[11] = '{1, 8'h0A, 16'h5555, 0, 1, 16'h0000};
        tbl[12] = '{0, 8'h0A, 16'h0000, 1, 0, 16'h7700};
        tbl[13] = '{0, 8'h0B, 16'h0000, 0, 1, 16'h0055};
        tbl[14] = '{1, 8'h0C, 16'hFFFF, 1, 1, 16'h0000};
        tbl[15] = '{0, 8'h0C, 16'h0000, 1, 1, 16'h0000};
        tbl[16] = '{0, 8'h00, 16'h0000, 1, 1, 16'h0000};
        tbl[17] = '{1, 8'h06, 16'h0040, 1, 1, 16'h0000};
        tbl[18] = '{0, 8'h06, 16'h0000, 1, 1, 16'h0040};
        tbl[19] = '{1, 8'h0A, 16'h0000, 1, 1, 16'h0000};
        tbl[20] = '{0, 8'h0A, 16'h0000, 1, 1, 16'h0000};
        tbl[21] = '{1, 8'h02, 16'hFF00, 1, 0, 16'h0000};
        tbl[22] = '{0, 8'h02, 16'h0000, 1, 1, 16'h0000};
        tbl[23] = '{0, 8'h1E, 16'h0000, 1, 1, 16'h0000};

        for (int i = 0; i < 24; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].a, tbl[i].d, tbl[i].u, tbl[i].l);
            end else begin
                do_read(tbl[i].a, tbl[i].u, tbl[i].l, rd);
                check($sformatf("table_read_%0d", i), int'(rd), int'(tbl[i].exp));
            end
        end

        // Two sources at levels 4 and 2; latency check of ipl_n.
        do_write(8'h00, 16'h0001, 1, 1);
        do_write(8'h02, 16'h0005, 1, 1);
        do_write(8'h08, 16'h0204, 1, 1);
        @(posedge clk); #1 irq = 8'h05;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ipl_before_latency", int'(ipl_n), 7);
        @(posedge clk); @(negedge clk);
        check("ipl_after_latency", int'(ipl_n), 3);
        @(posedge clk); #1 irq = 8'h00;
        repeat (4) @(posedge clk);
        m_pend = m_pend | ('h05 & m_en);
        do_read(8'h04, 1, 1, rd);
        check("pending_two_src", int'(rd), 'h05);

        // Acknowledge level 4: src0 vector, clear visible one edge after ack.
        do_iack(3'd4, rd, pa, pf);
        check("iack4_vector", int'(rd), 'h0040);
        check("iack4_ipl_at_ack", int'(pa), 3);
        check("iack4_ipl_after", int'(pf), 5);
        do_read(8'h04, 1, 1, rd);
        check("iack4_pending", int'(rd), 'h04);

        // Spurious acknowledge.
        do_iack(3'd6, rd, pa, pf);
        check("iack6_spurious", int'(rd), 'h0018);
        do_read(8'h04, 1, 1, rd);
        check("iack6_pending", int'(rd), 'h04);

        // W1C of PENDING[2] in the same cycle as a new irq[2] edge.
        @(posedge clk); #1 irq = 8'h04;
        do_write(8'h04, 16'h0004, 1, 1);
        m_pend = m_pend | ('h04 & m_en);
        @(posedge clk); #1 irq = 8'h00;
        repeat (4) @(posedge clk);
        do_read(8'h04, 1, 1, rd);
        check("w1c_vs_edge", int'(rd), 'h04);
        do_write(8'h04, 16'h0004, 1, 1);
        do_read(8'h04, 1, 1, rd);
        check("w1c_clear", int'(rd), 'h00);
        check("w1c_ipl", int'(ipl_n), 7);

        // Global disable masks ipl_n but keeps PENDING.
        pulse_irq(8'h01);
        check("mask_ipl_on", int'(ipl_n), 3);
        do_write(8'h00, 16'h0000, 1, 1);
        check("mask_ipl_off", int'(ipl_n), 7);
        do_read(8'h04, 1, 1, rd);
        check("mask_pending_kept", int'(rd), 'h01);
        do_write(8'h00, 16'h0001, 1, 1);
        check("mask_ipl_restored", int'(ipl_n), 3);

        // Long strobe gives a single ack.
        bus_cycle(1'b0, 3'd0, 1'b1, 8'h00, 16'h0, 1'b1, 1'b1, 7, rd, n, at, pa, pf);
        check("long_strobe_acks", n, 1);
        check("long_strobe_data", int'(rd), 1);

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    ra = 8'(($urandom_range(0, 7) * 2) + $urandom_range(0, 1));
                    do_write(ra, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                1: begin
                    ra = 8'(($urandom_range(0, 7) * 2) + $urandom_range(0, 1));
                    do_read(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd);
                end
                2: pulse_irq(8'($urandom_range(0, 255)));
                default: do_iack(3'($urandom_range(0, 7)), rd, pa, pf);
            endcase
            check("rand_ipl_n", int'(ipl_n), m_ipl());
        end

        // Reset asserted while an IACK cycle is in progress.
        @(posedge clk); #1;
        as = 1'b1; iack = 1'b1; iack_level = 3'd3; rw = 1'b1;
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_iack_ack", int'(ack), 0);
        check("reset_mid_iack_data", int'(data_read), 0);
        check("reset_mid_iack_ipl", int'(ipl_n), 7);
        as = 1'b0; iack = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        m_reset();
        do_read(8'h06, 1, 1, rd);
        check("post_reset_vbase", int'(rd), 'h40);
        do_read(8'h02, 1, 1, rd);
        check("post_reset_enable", int'(rd), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
